// File: rtl/codec_cfg_sequencer_if.sv
// Handshake bundle between the codec config sequencer and the I2C byte engine.
// Latency: none, wires only.
// Backpressure: the engine stalls the sequencer through i2c_ready/i2c_busy.
interface codec_cfg_sequencer_if;
  logic       i2c_ready;
  logic       i2c_busy;
  logic       i2c_nack;
  logic       i2c_enable;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_byte;

  // Sequencer side: issues byte requests, observes engine status
  modport master (
    input  i2c_ready, i2c_busy, i2c_nack,
    output i2c_enable, i2c_addr, i2c_byte
  );

  // Byte engine side
  modport slave (
    output i2c_ready, i2c_busy, i2c_nack,
    input  i2c_enable, i2c_addr, i2c_byte
  );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// Walks a fixed 7-entry codec register table, sending each entry as two I2C bytes.
// Latency: one cycle per FSM hop; GAP_CYCLES idle cycles after every completed entry.
// Backpressure: holds i2c_enable/i2c_byte until i2c_busy rises; NACK retry under CODEC_CFG_RETRY_EN.
module codec_cfg_sequencer #(
  parameter logic [6:0] PERIPH_ADDR = 7'h1A,
  parameter int         GAP_CYCLES  = 1000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  codec_cfg_sequencer_if.master        bus,
  output logic [2:0]                   step,
  output logic                         done,
  output logic                         error
);

  // Counter only ever needs to reach GAP_CYCLES-1
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_READY,
    SEND_HI,
    HOLD_HI,
    SEND_LO,
    HOLD_LO,
    GAP,
    DONE,
    ERROR
  } state_t;

  state_t          r_state;
  logic [2:0]      r_step;
  logic            r_enable;
  logic [7:0]      r_byte;
  logic            r_done;
  logic            r_error;
  logic [GW-1:0]   r_gap_cnt;
  logic [15:0]     w_entry;

`ifdef CODEC_CFG_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  logic [RW-1:0]   r_retry;
  // Set when the current GAP is a back-off before resending the same entry
  logic            r_resend;
`endif

  // Table entry = {reg[6:0], data[8:0]}; the high byte is simply entry[15:8]
  function automatic logic [15:0] f_table(input logic [2:0] idx);
    case (idx)
      3'd0:    return {7'd15, 9'h000};
      3'd1:    return {7'd6,  9'h000};
      3'd2:    return {7'd4,  9'h012};
      3'd3:    return {7'd5,  9'h000};
      3'd4:    return {7'd7,  9'h080};
      3'd5:    return {7'd8,  9'h000};
      3'd6:    return {7'd9,  9'h001};
      default: return 16'h0000;
    endcase
  endfunction

  assign w_entry        = f_table(r_step);
  assign bus.i2c_enable = r_enable;
  assign bus.i2c_byte   = r_byte;
  assign bus.i2c_addr   = PERIPH_ADDR;
  assign step           = r_step;
  assign done           = r_done;
  assign error          = r_error;

  // Sequencer FSM with all outputs registered; async reset kills a transfer at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= 3'd0;
      r_enable  <= 1'b0;
      r_byte    <= 8'h00;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_gap_cnt <= '0;
`ifdef CODEC_CFG_RETRY_EN
      r_retry   <= '0;
      r_resend  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= WAIT_READY;
          r_step  <= 3'd0;
        end

        WAIT_READY: begin
          if (bus.i2c_ready) begin
            r_state  <= SEND_HI;
            r_enable <= 1'b1;
            r_byte   <= w_entry[15:8];
          end
        end

        // Keep the request up with a stable byte until the engine takes it
        SEND_HI, SEND_LO: begin
          if (bus.i2c_busy) begin
            r_state  <= (r_state == SEND_HI) ? HOLD_HI : HOLD_LO;
            r_enable <= 1'b0;
          end
        end

        // NACK is only meaningful on the cycle busy drops
        HOLD_HI, HOLD_LO: begin
          if (!bus.i2c_busy) begin
            if (bus.i2c_nack) begin
`ifdef CODEC_CFG_RETRY_EN
              if (r_retry == RETRY_LAST) begin
                r_state <= ERROR;
                r_error <= 1'b1;
              end else begin
                r_retry   <= r_retry + RW'(1);
                r_resend  <= 1'b1;
                r_gap_cnt <= '0;
                r_state   <= GAP;
              end
`else
              r_state <= ERROR;
              r_error <= 1'b1;
`endif
            end else if (r_state == HOLD_HI) begin
              r_state  <= SEND_LO;
              r_enable <= 1'b1;
              r_byte   <= w_entry[7:0];
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
`ifdef CODEC_CFG_RETRY_EN
              r_retry   <= '0;
              r_resend  <= 1'b0;
`endif
            end
          end
        end

        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
`ifdef CODEC_CFG_RETRY_EN
            if (r_resend) begin
              r_resend <= 1'b0;
              r_state  <= WAIT_READY;
            end else if (r_step == 3'd6) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= WAIT_READY;
            end
`else
            if (r_step == 3'd6) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= WAIT_READY;
            end
`endif
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end

        // Terminal states: only start re-runs the table from entry 0
        DONE, ERROR: begin
          if (start) begin
            r_state <= WAIT_READY;
            r_step  <= 3'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            r_retry  <= '0;
            r_resend <= 1'b0;
`endif
          end
        end

        default: begin
          r_state  <= IDLE;
          r_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C byte engine.
// Latency: n/a.
// Backpressure: the engine model stalls via configurable busy delay/length.
module tb_codec_cfg_sequencer;

  localparam int G = 16;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] step;
  logic       done;
  logic       error;

  codec_cfg_sequencer_if bus_if ();

  codec_cfg_sequencer #(
    .PERIPH_ADDR(7'h1A),
    .GAP_CYCLES (G),
    .MAX_RETRY  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .bus  (bus_if),
    .step (step),
    .done (done),
    .error(error)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Engine knobs and record of every byte it accepted
  int         eng_delay    = 1;
  int         eng_busy_len = 2;
  int         nack_left    = 0;
  logic [7:0] nack_val     = 8'h00;
  logic [7:0] sent_q[$];
  int         sent_cyc[$];

  logic [7:0] exp_seq [14] = '{8'h1E, 8'h00, 8'h0C, 8'h00, 8'h08, 8'h12, 8'h0A,
                               8'h00, 8'h0E, 8'h80, 8'h10, 8'h00, 8'h12, 8'h01};
  logic [7:0] exp_retry [16] = '{8'h1E, 8'h00, 8'h0C, 8'h00, 8'h08, 8'h12, 8'h08, 8'h12,
                                 8'h0A, 8'h00, 8'h0E, 8'h80, 8'h10, 8'h00, 8'h12, 8'h01};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int limit);
    for (int i = 0; i < limit && !(done || error); i++) @(negedge clk);
    chk(tag, {31'd0, done | error}, 32'd1);
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_count"}, sent_q.size(), 14);
    if (sent_q.size() == 14) begin
      for (int i = 0; i < 14; i++)
        chk($sformatf("%s_b%0d", tag, i), {24'd0, sent_q[i]}, {24'd0, exp_seq[i]});
    end
  endtask

  // Behavioural byte engine: accepts on enable, optional stall, busy pulse, NACK on demand
  initial begin
    logic [7:0] b;
    logic       do_nack;
    bus_if.i2c_ready = 1'b1;
    bus_if.i2c_busy  = 1'b0;
    bus_if.i2c_nack  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus_if.i2c_enable) begin
        b = bus_if.i2c_byte;
        sent_q.push_back(b);
        sent_cyc.push_back(cyc);
        repeat (eng_delay) @(negedge clk);
        bus_if.i2c_ready = 1'b0;
        bus_if.i2c_busy  = 1'b1;
        repeat (eng_busy_len) @(negedge clk);
        do_nack = (b == nack_val) && (nack_left > 0);
        if (do_nack) nack_left--;
        bus_if.i2c_busy = 1'b0;
        bus_if.i2c_nack = do_nack;
        @(negedge clk);
        bus_if.i2c_nack  = 1'b0;
        bus_if.i2c_ready = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] b0;
    logic [2:0] s0;
    int         bad;

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_enable", {31'd0, bus_if.i2c_enable}, 0);
    chk("rst_byte",   {24'd0, bus_if.i2c_byte}, 0);
    chk("rst_step",   {29'd0, step}, 0);
    chk("rst_done",   {31'd0, done}, 0);
    chk("rst_error",  {31'd0, error}, 0);
    chk("addr",       {25'd0, bus_if.i2c_addr}, 32'h1A);

    // Run 1: first byte stalled 50 cycles, then full table
    eng_delay = 50;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 20 && !bus_if.i2c_enable; i++) @(negedge clk);
    chk("first_en_timeout", {31'd0, bus_if.i2c_enable}, 1);
    b0  = bus_if.i2c_byte;
    s0  = step;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus_if.i2c_enable === 1'b1 && bus_if.i2c_byte === b0 && step === s0)) bad++;
    end
    eng_delay = 1;
    chk("stall_hold", bad, 0);
    chk("stall_byte", {24'd0, b0}, 32'h1E);
    wait_end("run1_timeout", 3000);
    check_full("run1");
    if (sent_q.size() == 14) begin
      for (int k = 0; k < 6; k++)
        chk($sformatf("run1_gap%0d", k),
            {31'd0, (sent_cyc[2*k+2] - sent_cyc[2*k+1]) >= G}, 1);
    end
    chk("run1_done",  {31'd0, done}, 1);
    chk("run1_error", {31'd0, error}, 0);
    chk("run1_step",  {29'd0, step}, 6);
    chk("run1_en",    {31'd0, bus_if.i2c_enable}, 0);

    // Run 2: start in DONE restarts; start at step 4 is ignored
    sent_q.delete();
    sent_cyc.delete();
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 0);
    chk("restart_step",     {29'd0, step}, 0);
    for (int i = 0; i < 3000 && step != 3'd4; i++) @(negedge clk);
    chk("step4_timeout", {29'd0, step}, 4);
    pulse_start();
    chk("ign_start_step", {29'd0, step}, 4);
    chk("ign_start_done", {31'd0, done}, 0);
    wait_end("run2_timeout", 3000);
    check_full("run2");
    chk("run2_done", {31'd0, done}, 1);

    // Run 3: one NACK on the low byte of entry 2
    nack_val  = 8'h12;
    nack_left = 1;
    sent_q.delete();
    sent_cyc.delete();
    pulse_start();
    wait_end("run3_timeout", 3000);
`ifdef CODEC_CFG_RETRY_EN
    chk("run3_done",  {31'd0, done}, 1);
    chk("run3_error", {31'd0, error}, 0);
    chk("run3_count", sent_q.size(), 16);
    if (sent_q.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("run3_b%0d", i), {24'd0, sent_q[i]}, {24'd0, exp_retry[i]});
    end
`else
    chk("run3_error", {31'd0, error}, 1);
    chk("run3_done",  {31'd0, done}, 0);
    chk("run3_step",  {29'd0, step}, 2);
    chk("run3_count", sent_q.size(), 6);
`endif

    // Run 4: every transfer of entry 0 is NACKed
    nack_val  = 8'h1E;
    nack_left = 100;
    sent_q.delete();
    sent_cyc.delete();
    pulse_start();
    wait_end("run4_timeout", 3000);
    nack_left = 0;
    chk("run4_error", {31'd0, error}, 1);
    chk("run4_done",  {31'd0, done}, 0);
    chk("run4_step",  {29'd0, step}, 0);
`ifdef CODEC_CFG_RETRY_EN
    chk("run4_attempts", sent_q.size(), 4);
`else
    chk("run4_attempts", sent_q.size(), 1);
`endif
    bad = 0;
    foreach (sent_q[i]) if (sent_q[i] !== 8'h1E) bad++;
    chk("run4_bytes", bad, 0);

    // Run 5: reset while waiting out the low byte of entry 3
    eng_busy_len = 4;
    sent_q.delete();
    sent_cyc.delete();
    pulse_start();
    for (int i = 0; i < 3000 && sent_q.size() < 8; i++) @(negedge clk);
    chk("run5_reach_e3", sent_q.size(), 8);
    for (int i = 0; i < 20 && !bus_if.i2c_busy; i++) @(negedge clk);
    chk("run5_busy", {31'd0, bus_if.i2c_busy}, 1);
    @(posedge clk);
    #1;
    chk("run5_pre_step", {29'd0, step}, 3);
    reset = 1'b1;
    #1;
    chk("run5_rst_en",    {31'd0, bus_if.i2c_enable}, 0);
    chk("run5_rst_byte",  {24'd0, bus_if.i2c_byte}, 0);
    chk("run5_rst_step",  {29'd0, step}, 0);
    chk("run5_rst_done",  {31'd0, done}, 0);
    chk("run5_rst_error", {31'd0, error}, 0);
    repeat (10) @(negedge clk);
    eng_busy_len = 2;
    sent_q.delete();
    sent_cyc.delete();
    reset = 1'b0;
    for (int i = 0; i < 100 && sent_q.size() == 0; i++) @(negedge clk);
    chk("run5_first_cnt", {31'd0, sent_q.size() > 0}, 1);
    if (sent_q.size() > 0) chk("run5_first_byte", {24'd0, sent_q[0]}, 32'h1E);
    wait_end("run5_timeout", 3000);
    check_full("run5");
    chk("run5_done", {31'd0, done}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
